byte_serial_adder: RTL

Multi-cycle WIDTH-bit add/subtract sequencer that time-shares one 8-bit carry-lookahead slice across the operand, one byte per clock, least-significant byte first. It sits beside the single-cycle ALU adder as the area-reduced arithmetic path for multi-cycle ALU operations. Operands are latched on a start handshake. The slice carry-out is registered between bytes, and a one-cycle done pulse is raised when the full result, carry-out and signed overflow are valid.

---
 rtl/byte_serial_adder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/byte_serial_adder.sv
// byte_serial_adder
//   Multi-cycle WIDTH-bit add/subtract engine. One 8-bit carry-lookahead
//   slice is reused across the operand, least-significant byte first, one
//   byte per clock. The carry between bytes is held in a register.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   start    : operation request, sampled only while idle
//   sub      : 0 = opA + opB, 1 = opA - opB (sampled with start)
//   opA, opB : WIDTH-bit operands (sampled with start)
//   busy     : high from the accepting edge until the return to idle
//   done     : one-cycle pulse; result/cout/overflow are complete
//   result   : sum/difference, held until the next accepted start
//   cout     : carry out of bit WIDTH-1 (for sub, 1 means no borrow)
//   overflow : signed overflow of the operation
module byte_serial_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned NSLICE = WIDTH / 8;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             overflow_q;

   logic             accept;
   logic             last;
   logic [IDXW+2:0]  bit_ofs;
   logic [7:0]       a_byte;
   logic [7:0]       b_byte;
   logic [7:0]       p;
   logic [7:0]       g;
   logic [8:0]       c;
   logic [7:0]       sum_byte;

   assign accept  = (state_q == IDLE) && start;
   assign last    = (idx_q == LAST_IDX);
   assign bit_ofs = {idx_q, 3'b000};

   // ---------------------------------------------------------------
   // Shared 8-bit carry-lookahead slice
   // ---------------------------------------------------------------
   always_comb begin
      a_byte   = a_q[bit_ofs +: 8];
      b_byte   = b_q[bit_ofs +: 8];
      p        = a_byte | b_byte;
      g        = a_byte & b_byte;
      c        = '0;
      c[0]     = carry_q;
      for (int unsigned i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      sum_byte = a_byte ^ b_byte ^ c[7:0];
   end

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
         a_q        <= opA;
         b_q        <= sub ? ~opB : opB;
         carry_q    <= sub;
         idx_q      <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (state_q == RUN) begin
         result_q[bit_ofs +: 8] <= sum_byte;
         carry_q                <= c[8];
         if (last) begin
            cout_q     <= c[8];
            overflow_q <= c[7] ^ c[8];
         end else begin
            // Held at the last index so the counter never wraps mid-run.
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = overflow_q;

endmodule
